uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_DIV, default 434, gives clk cycles per UART bit (50 MHz / 115200); legal range 8..65535, even.
REQ-002 Parameter SYNC_STAGES, default 2, sets the number of input synchronizer flops on rx_pin; legal range 2..3.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_pin  input  1  asynchronous serial line; idles high.
REQ-006 uart_rx_data  output  8  last correctly framed byte.
REQ-007 uart_rx_done  output  1  one-cycle pulse; uart_rx_data is valid in that cycle.
REQ-008 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 rx_busy  output  1  high from start-bit acceptance until return to IDLE.

Function
REQ-010 rx_pin SHALL pass through SYNC_STAGES flops; all decisions use the synchronized value rx_s only.
REQ-011 Frame format SHALL be 1 start (low), 8 data LSB-first, 1 stop (high), no parity.
REQ-012 States SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: on rx_s==0, load baud counter with BAUD_DIV/2-1 and go to START; no other action.
REQ-014 START: at counter==0, sample rx_s; if 1 (glitch), return to IDLE with no output pulse; if 0, load BAUD_DIV-1, clear bit index, and go to DATA.
REQ-015 DATA: at each counter==0, shift rx_s into the MSB of the shift register (right shift) and reload BAUD_DIV-1; after the 8th sample, go to STOP.
REQ-016 STOP: at counter==0, if rx_s==1, copy the shift register to uart_rx_data, pulse uart_rx_done, and go to IDLE in the same edge.
REQ-017 STOP: at counter==0, if rx_s==0, pulse frame_err, leave uart_rx_data unchanged, and go to WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until rx_s==1, then go to IDLE; a held-low line (break) SHALL produce no further pulses.
REQ-019 uart_rx_data SHALL change only on the edge that raises uart_rx_done and SHALL hold until the next successful frame.
REQ-020 Latency: uart_rx_done SHALL be high exactly SYNC_STAGES + 9*BAUD_DIV + BAUD_DIV/2 + 1 cycles after the first edge that captures rx_pin low.
REQ-021 uart_rx_done and frame_err SHALL never both be high; each is high for exactly one cycle.
REQ-022 Back-to-back frames: a start bit arriving immediately after the stop-bit sample SHALL be accepted with no byte loss.
REQ-023 rx_busy SHALL be 0 in IDLE and 1 in START, DATA, STOP and WAIT_IDLE.
REQ-024 The baud counter SHALL be $clog2(BAUD_DIV) bits wide and SHALL never underflow.
REQ-025 The bit index SHALL be 3 bits wide, with the terminal condition on index==7.
REQ-026 No handshake back-pressure exists; a consumer missing a uart_rx_done pulse loses that byte.

Reset
REQ-027 On rst_n low: state=IDLE; uart_rx_data=8'h00; uart_rx_done=0; frame_err=0; rx_busy=0; counter=0; shift register=0; synchronizer flops=1 (idle).
REQ-028 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-029 After reset deassertion, a line already low SHALL be treated as a new start bit.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum typedef uart_rx_state_t, the default BAUD_DIV constant and the frame-width constant 8.
REQ-031 The synchronizer SHALL be one sub-module, sync_ff, parameterized by depth and reset value.
REQ-032 The block SHALL connect directly to the matrix FSM ports uart_rx_data and uart_rx_done with no glue logic.

Verification
Benches SHALL use BAUD_DIV=16 and SYNC_STAGES=2.
REQ-033 Send 0xA5 -> one uart_rx_done pulse at cycle 2+144+8+1=155 after start, uart_rx_data=0xA5, frame_err never high.
REQ-034 Send 0x00 then 0xFF back-to-back with zero idle time -> two pulses 160 cycles apart, data 0x00 then 0xFF.
REQ-035 Drive the line low for 5 cycles then high -> no pulse, rx_busy returns to 0, and a following 0x3C is received correctly.
REQ-036 Send 0x5A with the stop bit low, then hold the line low for 40 cycles -> exactly one frame_err pulse, uart_rx_data keeps its prior value, no uart_rx_done; the next 0x81 is received correctly after the line returns high.
REQ-037 Assert rst_n at bit 4 of 0xC3 -> all outputs reset, no pulse; after release, 0x96 is received as 0x96.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int unsigned c_BAUD_DIV_DEF = 434;
  localparam int unsigned c_FRAME_BITS   = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// Module      : sync_ff
// Description : Multi-flop synchronizer with a configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff #(
  parameter int unsigned DEPTH   = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, mid-bit sampling, one-cycle done/error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = c_BAUD_DIV_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_pin,
  output logic [c_FRAME_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_done,
  output logic                    frame_err,
  output logic                    rx_busy
);

  localparam int unsigned   CW     = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] c_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] c_FULL = CW'(BAUD_DIV - 1);

  logic                    rx_s;
  uart_rx_state_t          state_q;
  logic [CW-1:0]           cnt_q;
  logic [2:0]              bit_idx_q;
  logic [c_FRAME_BITS-1:0] shift_q;
  logic [c_FRAME_BITS-1:0] data_q;
  logic                    done_q;
  logic                    ferr_q;
  logic                    busy_q;

  sync_ff #(
    .DEPTH   (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_pin),
    .q_o   (rx_s)
  );

  // Pulses default low every edge; the counter only decrements when non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt_q   <= c_HALF;
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt_q == '0) begin
            if (rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q     <= c_FULL;
              bit_idx_q <= '0;
              state_q   <= ST_DATA;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rx_s, shift_q[c_FRAME_BITS-1:1]};
            cnt_q   <= c_FULL;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == '0) begin
            if (rx_s) begin
              data_q  <= shift_q;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_WAIT_IDLE: begin
          // A break holds the line low; stay here silently until it releases.
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_rx_data = data_q;
  assign uart_rx_done = done_q;
  assign frame_err    = ferr_q;
  assign rx_busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (BAUD_DIV=16, 2 sync stages).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int BD = 16;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] uart_rx_data;
  logic       uart_rx_done;
  logic       frame_err;
  logic       rx_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;
  int n_ferr  = 0;
  int n_overlap = 0;
  int n_wide  = 0;
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;
  int         done_cyc_q[$];
  logic [7:0] done_dat_q[$];
  int t_start;
  int base_done;
  int base_ferr;
  int base_idx;

  uart_rx #(
    .BAUD_DIV    (BD),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_pin       (rx_pin),
    .uart_rx_data (uart_rx_data),
    .uart_rx_done (uart_rx_done),
    .frame_err    (frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (uart_rx_done) begin
      n_done <= n_done + 1;
      done_cyc_q.push_back(cyc);
      done_dat_q.push_back(uart_rx_data);
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (uart_rx_done && frame_err) n_overlap <= n_overlap + 1;
    if ((uart_rx_done && prev_done) || (frame_err && prev_ferr)) n_wide <= n_wide + 1;
    prev_done <= uart_rx_done;
    prev_ferr <= frame_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qcyc(input int i);
    return (i < done_cyc_q.size()) ? done_cyc_q[i] : -1;
  endfunction

  function automatic logic [7:0] qdat(input int i);
    return (i < done_dat_q.size()) ? done_dat_q[i] : 8'hxx;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_pin = v;
    wait_cyc(BD);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  initial begin
    // Reset state
    wait_cyc(3);
    chk("rst_data", uart_rx_data, 8'h00);
    chk("rst_done", uart_rx_done, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Single frame 0xA5, latency 2 + 144 + 8 + 1
    base_done = n_done;
    base_idx  = done_cyc_q.size();
    send_byte(8'hA5, 1'b1);
    wait_cyc(4);
    chk("a5_count", n_done - base_done, 1);
    chk("a5_latency", qcyc(base_idx) - t_start, 155);
    chk("a5_data", qdat(base_idx), 8'hA5);
    chk("a5_port", uart_rx_data, 8'hA5);
    chk("a5_ferr", n_ferr, 0);
    chk("a5_busy", rx_busy, 1'b0);

    // Back-to-back 0x00 then 0xFF, no idle gap
    base_done = n_done;
    base_idx  = done_cyc_q.size();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_cyc(4);
    chk("b2b_count", n_done - base_done, 2);
    chk("b2b_gap", qcyc(base_idx + 1) - qcyc(base_idx), 160);
    chk("b2b_data0", qdat(base_idx), 8'h00);
    chk("b2b_data1", qdat(base_idx + 1), 8'hFF);

    // Five-cycle glitch is rejected, then 0x3C
    base_done = n_done;
    rx_pin = 1'b0;
    wait_cyc(5);
    chk("glitch_busy_hi", rx_busy, 1'b1);
    rx_pin = 1'b1;
    wait_cyc(20);
    chk("glitch_busy_lo", rx_busy, 1'b0);
    chk("glitch_nopulse", n_done - base_done, 0);
    chk("glitch_noferr", n_ferr, 0);
    base_idx = done_cyc_q.size();
    send_byte(8'h3C, 1'b1);
    wait_cyc(4);
    chk("3c_count", n_done - base_done, 1);
    chk("3c_data", qdat(base_idx), 8'h3C);

    // 0x5A with low stop bit, then a 40-cycle break
    base_done = n_done;
    base_ferr = n_ferr;
    send_byte(8'h5A, 1'b0);
    wait_cyc(40);
    chk("ferr_count", n_ferr - base_ferr, 1);
    chk("ferr_nodone", n_done - base_done, 0);
    chk("ferr_data_kept", uart_rx_data, 8'h3C);
    chk("ferr_busy_break", rx_busy, 1'b1);
    rx_pin = 1'b1;
    wait_cyc(10);
    chk("ferr_busy_lo", rx_busy, 1'b0);
    base_idx = done_cyc_q.size();
    send_byte(8'h81, 1'b1);
    wait_cyc(4);
    chk("81_count", n_done - base_done, 1);
    chk("81_data", qdat(base_idx), 8'h81);
    chk("ferr_total", n_ferr - base_ferr, 1);

    // Reset asserted during bit 4 of 0xC3
    base_done = n_done;
    base_ferr = n_ferr;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx_pin = 1'b0;
    wait_cyc(3);
    chk("mid_busy", rx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_data", uart_rx_data, 8'h00);
    chk("mrst_done", uart_rx_done, 1'b0);
    chk("mrst_ferr", frame_err, 1'b0);
    chk("mrst_busy", rx_busy, 1'b0);
    wait_cyc(5);
    rx_pin = 1'b1;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(30);
    chk("mrst_nopulse", n_done - base_done, 0);
    chk("mrst_noferr", n_ferr - base_ferr, 0);
    base_idx = done_cyc_q.size();
    send_byte(8'h96, 1'b1);
    wait_cyc(4);
    chk("96_count", n_done - base_done, 1);
    chk("96_data", qdat(base_idx), 8'h96);

    // Pulse exclusivity and single-cycle width over the whole run
    chk("overlap", n_overlap, 0);
    chk("pulse_width", n_wide, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
